// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and
// the command/response bytes exchanged with the keyboard.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_e;

  // 100 us clock-low inhibit and 15 ms ACK timeout at 50 MHz.
  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a registered
// falling-edge detector on the clock; shared by the receive and transmit paths.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;

  // Idle bus is high; resetting to 1 prevents a spurious fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff_q   <= '1;
      dat_ff_q   <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
      dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign clk_sync_o = clk_ff_q[1];
  assign dat_sync_o = dat_ff_q[1];
  assign fall_o     = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, odd parity,
// stop, ACK). Define PS2_TX_TIMEOUT_EN to add the clock-release-to-ACK timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be nonzero");
  end

  ps2_tx_state_e    state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             clk_s, dat_s, fall;
  logic             timeout_hit;

  ps2_sync_edge u_sync (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_dat_i  (ps2_dat_in),
    .clk_sync_o (clk_s),
    .dat_sync_o (dat_s),
    .fall_o     (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q, to_d;
  logic            to_active;

  assign to_active = (state_q == ST_SEND) || (state_q == ST_ACK);

  // Held at zero outside SEND/ACK, so it restarts at clock release; saturates.
  always_comb begin
    to_d = '0;
    if (to_active) begin
      to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  // Hit on the last counted cycle so ERR appears TIMEOUT_CYCLES after release.
  assign timeout_hit = to_active && (to_q >= TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          par_d    = ps2_odd_parity(tx_data);
          inh_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          bit_d    = '0;
          state_d  = ST_SEND;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q < 4'd8) begin
            dat_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          state_d = dat_s ? ST_ERR : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      state_d  = ST_ERR;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      inh_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inh_q    <= inh_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 5000;
  localparam int unsigned TO   = 3000;
  localparam int unsigned HALF = 20;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned EXP_ERRS = 2;
`else
  localparam int unsigned EXP_ERRS = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~ps2_clk_oe & ~dev_clk_low;
  assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done),
    .error      (error),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  typedef struct {
    bit          exp_err;
    logic [7:0]  data;
    logic        par;
    bit          chk_bits;
    int unsigned to_delay;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  longint      cyc = 0;
  longint      rel_cyc = 0;
  logic        prev_clk_oe = 1'b0;
  logic        cap_start, cap_par, cap_stop;
  logic [7:0]  cap_data;
  int unsigned cap_inh;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0) rel_cyc <= cyc;
    prev_clk_oe <= ps2_clk_oe;
  end

  // Monitor: every done/error pulse retires the oldest expected transfer.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (done === 1'b1 || error === 1'b1) begin
        if (done === 1'b1) done_cnt++;
        else err_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%b error=%b with nothing outstanding", done, error);
        end else begin
          e = sb.pop_front();
          chk({e.name, " outcome{done,error}"}, 32'({done, error}), e.exp_err ? 32'h1 : 32'h2);
          chk({e.name, " oe_idle"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'h0);
          chk({e.name, " inhibit_len"}, 32'(cap_inh), 32'(INH));
          chk({e.name, " start_bit"}, 32'(cap_start), 32'h0);
          if (e.chk_bits) begin
            chk({e.name, " data"}, 32'(cap_data), 32'(e.data));
            chk({e.name, " parity"}, 32'(cap_par), 32'(e.par));
            chk({e.name, " stop"}, 32'(cap_stop), 32'h1);
          end
          if (e.to_delay != 0) begin
            chk({e.name, " timeout_delay"}, 32'(cyc - rel_cyc), 32'(e.to_delay));
          end
          @(negedge CLOCK_50);
          chk({e.name, " ready_after{rdy,done,err}"}, 32'({tx_ready, done, error}), 32'h4);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    chk("accept{rdy,clk_oe}", 32'({tx_ready, ps2_clk_oe}), 32'h1);
  endtask

  // Device: time the inhibit, then clock nclk bits, sampling data on each rise.
  task automatic device(input int nclk, input bit ack);
    int t;
    cap_start = 1'bx;
    cap_par   = 1'bx;
    cap_stop  = 1'bx;
    cap_data  = 'x;
    cap_inh   = 0;
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 200) begin
      @(negedge CLOCK_50);
      t++;
    end
    while (ps2_clk_oe === 1'b1 && cap_inh < 2 * INH) begin
      cap_inh++;
      @(negedge CLOCK_50);
    end
    cap_start = dat_line;
    repeat (4) @(negedge CLOCK_50);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (5) @(negedge CLOCK_50);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      if (k <= 8) cap_data[k-1] = dat_line;
      else if (k == 9) cap_par = dat_line;
      else if (k == 10) cap_stop = dat_line;
      repeat (HALF) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int t;
    t = 0;
    while (!(tx_ready === 1'b1 && sb.size() == 0) && t < limit) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk({nm, " completes_in_budget"}, 32'(t < limit), 32'h1);
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic xfer(input string nm, input logic [7:0] b, input logic par, input bit ack);
    sb.push_back('{exp_err: !ack, data: b, par: par, chk_bits: 1'b1, to_delay: 0, name: nm});
    send(b);
    device(11, ack);
    wait_idle(nm, 2000);
  endtask

  initial begin : watchdog
    #(20 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("reset tx_ready", 32'(tx_ready), 32'h1);
    chk("reset done", 32'(done), 32'h0);
    chk("reset error", 32'(error), 32'h0);
    chk("reset clk_oe", 32'(ps2_clk_oe), 32'h0);
    chk("reset dat_oe", 32'(ps2_dat_oe), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    xfer("ed", 8'hED, 1'b1, 1'b1);
    xfer("01", 8'h01, 1'b0, 1'b1);
    xfer("ff", 8'hFF, 1'b1, 1'b1);
    xfer("noack", 8'h3C, 1'b1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    sb.push_back('{exp_err: 1'b1, data: 8'h5A, par: 1'b1, chk_bits: 1'b0, to_delay: TO, name: "timeout"});
    send(8'h5A);
    device(0, 1'b0);
    wait_idle("timeout", TO + 200);
`endif

    // Abort after the 4th data bit: 0xA5 bit3 = 0, so data is being pulled low.
    send(8'hA5);
    device(4, 1'b0);
    chk("abort dat_oe_before", 32'(ps2_dat_oe), 32'h1);
    #3 reset = 1'b1;
    #1 chk("abort {clk_oe,dat_oe,done,err}", 32'({ps2_clk_oe, ps2_dat_oe, done, error}), 32'h0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    xfer("f4", 8'hF4, 1'b0, 1'b1);

    sb.push_back('{exp_err: 1'b0, data: 8'hED, par: 1'b1, chk_bits: 1'b1, to_delay: 0, name: "ed_busy"});
    fork
      begin
        send(8'hED);
        device(11, 1'b1);
      end
      begin
        repeat (200) @(negedge CLOCK_50);
        chk("busy {rdy,clk_oe}", 32'({tx_ready, ps2_clk_oe}), 32'h1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
      end
    join
    wait_idle("ed_busy", 2000);
    repeat (50) @(negedge CLOCK_50);
    chk("no_second_xfer {clk_oe,rdy}", 32'({ps2_clk_oe, tx_ready}), 32'h1);

    chk("done_count", 32'(done_cnt), 32'd5);
    chk("error_count", 32'(err_cnt), 32'(EXP_ERRS));
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the FPGA to the keyboard over the bidirectional open-collector `ps2_clk`/`ps2_dat` pair. It is the counterpart of the keyboard scan-code receive path: that path is clocked by the device toward the host, while this block drives the reverse direction for lock-LED control and keyboard initialisation. It sits beside the PS/2 receiver under `Top`, which builds the tri-states as `ps2_clk = ps2_clk_oe ? 1'b0 : 1'bz` and `ps2_dat = ps2_dat_oe ? 1'b0 : 1'bz`.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit time (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum time from clock release to ACK (15 ms).

Ports (one clock; reset is asynchronous and active-high):
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  block idle and able to accept a byte.
- `done`  out  1  one-cycle pulse: byte sent and ACK received.
- `error`  out  1  one-cycle pulse: missing ACK or timeout.
- `ps2_clk_in`  in  1  raw PS/2 clock pin.
- `ps2_dat_in`  in  1  raw PS/2 data pin.
- `ps2_clk_oe`  out  1  1 = pull clock low.
- `ps2_dat_oe`  out  1  1 = pull data low.

## Operation
- Pins pass through a 2-FF synchroniser; a registered falling-edge detector produces `fall`.
- Parity is odd: `par = ~^tx_data`.
- States and transitions:
  - IDLE: `tx_ready`=1, both OEs 0. On `tx_valid`, latch `tx_data` and `par`, then go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles. Then assert `ps2_dat_oe`=1 (start bit), release the clock, clear the timeout counter, clear the bit counter, and go to SEND.
  - SEND: on each `fall`, increment the bit counter n (1..10) and drive the pin:
    - n=1..8: data bit n-1, LSB first (`ps2_dat_oe` = ~bit).
    - n=9: parity bit.
    - n=10: release data (stop bit = 1).
    - After n=10, go to ACK.
  - ACK: on the next `fall`, sample the synchronised data. Low means go to WAIT_IDLE; high means go to ERR.
  - WAIT_IDLE: wait until the synchronised clock and data are both 1, then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
  - ERR: `error`=1 for one cycle, both OEs 0, then IDLE.
- `tx_valid` is ignored outside IDLE. There is no queueing.
- If `fall` arrives during INHIBIT it is ignored, because the host owns the clock in that state.

## Timing
- Reset values: `tx_ready`=1, `done`=0, `error`=0, `ps2_clk_oe`=0, `ps2_dat_oe`=0, state IDLE, all counters 0.
- Reset asserted mid-operation releases both lines immediately (asynchronous) and aborts without pulsing `done` or `error`.
- The accept handshake is a rising edge with `tx_valid & tx_ready`. `ps2_clk_oe` rises the next cycle and `tx_ready` falls the same cycle.
- Pin fall to data update takes 3 cycles (2 synchroniser + 1 edge detect). This is far below the device's ≥30 µs clock-low phase.
- A full transaction takes `INHIBIT_CYCLES` + 11 device clocks + idle wait. `tx_ready` returns high the cycle after the `done` or `error` pulse.
- Timeout counter:
  - Counts every cycle in SEND and ACK.
  - When it reaches `TIMEOUT_CYCLES`, go to ERR. This takes priority over a simultaneous `fall`.
  - The counter saturates and never wraps.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined: the timeout counter and its ERR transition are present, as described above.
- `PS2_TX_TIMEOUT_EN` undefined: there is no counter, and SEND/ACK wait indefinitely for device clocks. `error` is then raised only by a missing ACK.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum;
  - default `INHIBIT_CYCLES` and `TIMEOUT_CYCLES` constants;
  - command constants `PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_CMD_RESET`=8'hFF;
  - the ACK byte 8'hFA, used by the receiver.
- Sub-module `ps2_sync_edge` contains the 2-FF synchroniser and falling-edge detector. It is shared with the receiver.

## Test plan
- Send 8'hED with a device model that ACKs:
  - `ps2_clk_oe` is high exactly 5000 cycles.
  - The model samples data bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` pulses once and `error` stays 0.
- Send 8'h01 and check that parity is sampled as 0; send 8'hFF and check that parity is sampled as 1.
- The device model leaves data high on the 11th clock -> `error` pulses once, both OEs are 0, and `tx_ready` returns to 1.
- The device never clocks (`PS2_TX_TIMEOUT_EN` defined) -> `error` fires 750000 cycles after clock release and `done` stays 0.
- Assert `reset` after the 4th data bit -> both OEs drop within the same cycle, there is no `done` or `error`, and a following 8'hF4 transfer completes normally.
- Pulse `tx_valid` with 8'h55 during INHIBIT of an 8'hED transfer -> only 8'hED appears on the wire and exactly one `done` pulses.
